// File: rtl/ifu_enum.sv
// Shared types and constants for the hxd32 instruction fetch unit.
package ifu_enum;

  typedef enum logic [1:0] {
    FETCH_LO,
    FETCH_HI,
    VALID
  } fetch_state_t;

  localparam logic [1:0] INST_LEN_32 = 2'b11;
  localparam logic [2:0] PC_INC_2    = 3'd2;
  localparam logic [2:0] PC_INC_4    = 3'd4;

endpackage

// File: rtl/inst_align.sv
// Realigns one instruction out of a 32-bit word, given pc[1] and the
// halfword carried over from the previous word for straddling instructions.
module inst_align
  import ifu_enum::*;
#(
  parameter int XLEN = 32
) (
  input  logic            pc_hi,
  input  logic [XLEN-1:0] word,
  input  logic [15:0]     hw_buf,
  output logic [XLEN-1:0] inst,
  output logic            straddle,
  output logic            compressed
);

  logic [15:0] half;

  always_comb begin
    half       = pc_hi ? word[31:16] : word[15:0];
    compressed = (half[1:0] != INST_LEN_32);
    straddle   = pc_hi && !compressed;
    inst       = '0;
    if (compressed) begin
      inst[15:0] = half;
    end else if (pc_hi) begin
      inst[31:0] = {word[15:0], hw_buf};
    end else begin
      inst[31:0] = word[31:0];
    end
  end

endmodule

// File: rtl/inst_fetch.sv
// hxd32 instruction fetch: PC register, instruction RAM reads, one-word cache
// and realignment of compressed / word-straddling instructions.
//
// state    | meaning
// FETCH_LO | reading the word that holds pc
// FETCH_HI | reading the next word to finish a straddling 32-bit instruction
// VALID    | instruction presented, waiting for the decoder to consume it
module inst_fetch
  import ifu_enum::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            pc_wr_en_i,
  input  logic            pc_wr_sel_i,
  input  logic            pc_inc_sel_i,
  input  logic [XLEN-1:0] pc_jump_addr_i,
  output logic            iram_rd_en_o,
  output logic [XLEN-1:0] iram_rd_addr_o,
  input  logic            iram_rd_valid_i,
  input  logic [XLEN-1:0] iram_rd_data_i,
  output logic            inst_valid_o,
  output logic [XLEN-1:0] inst_data_o,
  output logic [XLEN-1:0] pc_data_o
);

  fetch_state_t    state, state_nxt;
  logic [XLEN-1:0] pc, pc_nxt, jump_pc, inst_q;
  logic [XLEN-1:0] cache_word;
  logic [XLEN-3:0] cache_tag, hi_tag;
  logic            cache_valid;
  logic [15:0]     hw_buf;

  logic            mem_pc_hi, mem_straddle, mem_compressed;
  logic [XLEN-1:0] mem_word, mem_inst;
  logic [XLEN-1:0] hit_inst;
  logic            hit_straddle, hit_compressed, hit;
  logic            rd_ack, consume;
  logic            unused_flags;

  assign hi_tag  = pc[XLEN-1:2] + (XLEN-2)'(1);
  assign jump_pc = pc_jump_addr_i & ~XLEN'(1);
  assign pc_nxt  = pc_wr_sel_i ? jump_pc
                 : pc + XLEN'(pc_inc_sel_i ? PC_INC_2 : PC_INC_4);
  assign rd_ack  = iram_rd_en_o && iram_rd_valid_i;
  assign consume = (state == VALID) && pc_wr_en_i;

  // In FETCH_HI the buffered upper half stands in for the word's upper half,
  // so the aligner's straddle output becomes {W[15:0], buffered half}.
  always_comb begin
    mem_pc_hi = pc[1];
    mem_word  = iram_rd_data_i;
    if (state == FETCH_HI) begin
      mem_pc_hi       = 1'b1;
      mem_word[31:16] = hw_buf;
    end
  end

  inst_align #(.XLEN(XLEN)) u_align_mem (
    .pc_hi      (mem_pc_hi),
    .word       (mem_word),
    .hw_buf     (hw_buf),
    .inst       (mem_inst),
    .straddle   (mem_straddle),
    .compressed (mem_compressed)
  );

  inst_align #(.XLEN(XLEN)) u_align_hit (
    .pc_hi      (pc_nxt[1]),
    .word       (cache_word),
    .hw_buf     (hw_buf),
    .inst       (hit_inst),
    .straddle   (hit_straddle),
    .compressed (hit_compressed)
  );

  assign hit          = cache_valid && (pc_nxt[XLEN-1:2] == cache_tag) && !hit_straddle;
  assign unused_flags = mem_compressed ^ hit_compressed;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state <= FETCH_LO;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    iram_rd_en_o   = 1'b0;
    iram_rd_addr_o = {pc[XLEN-1:2], 2'b00};
    case (state)
      FETCH_LO: begin
        iram_rd_en_o = 1'b1;
        if (iram_rd_valid_i) state_nxt = mem_straddle ? FETCH_HI : VALID;
      end
      FETCH_HI: begin
        iram_rd_en_o   = 1'b1;
        iram_rd_addr_o = {hi_tag, 2'b00};
        if (iram_rd_valid_i) state_nxt = VALID;
      end
      VALID: begin
        if (pc_wr_en_i) state_nxt = hit ? VALID : FETCH_LO;
      end
      default: state_nxt = FETCH_LO;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pc          <= RESET_PC;
      inst_q      <= '0;
      cache_word  <= '0;
      cache_tag   <= '0;
      cache_valid <= 1'b0;
      hw_buf      <= '0;
    end else begin
      if (rd_ack) begin
        cache_word  <= iram_rd_data_i;
        cache_valid <= 1'b1;
        cache_tag   <= (state == FETCH_HI) ? hi_tag : pc[XLEN-1:2];
        if (state == FETCH_LO && mem_straddle) hw_buf <= iram_rd_data_i[31:16];
        else                                   inst_q <= mem_inst;
      end
      if (consume) begin
        pc <= pc_nxt;
        if (hit) inst_q <= hit_inst;
      end
    end
  end

  assign inst_valid_o = (state == VALID);
  assign inst_data_o  = inst_q;
  assign pc_data_o    = pc;

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: randomized memory latency and decoder
// traffic, compared every cycle against a halfword-level memory model.
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en = 1'b0, wr_sel = 1'b0, inc_sel = 1'b0;
  logic [31:0] jump_addr = '0;
  logic        rd_en;
  logic [31:0] rd_addr;
  logic        rd_valid = 1'b0;
  logic [31:0] rd_data = '0;
  logic        inst_valid;
  logic [31:0] inst_data, pc_data;

  inst_fetch #(.XLEN(32), .RESET_PC(32'h0)) dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .pc_wr_en_i     (wr_en),
    .pc_wr_sel_i    (wr_sel),
    .pc_inc_sel_i   (inc_sel),
    .pc_jump_addr_i (jump_addr),
    .iram_rd_en_o   (rd_en),
    .iram_rd_addr_o (rd_addr),
    .iram_rd_valid_i(rd_valid),
    .iram_rd_data_i (rd_data),
    .inst_valid_o   (inst_valid),
    .inst_data_o    (inst_data),
    .pc_data_o      (pc_data)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_chk  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, required %h", name, act, exp);
  endtask

  // Memory: explicit overrides, otherwise a fixed hash of the word address.
  logic [31:0] mem_ovr [logic [31:0]];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w, x;
    w = {a[31:2], 2'b00};
    if (mem_ovr.exists(w)) return mem_ovr[w];
    x = {2'b00, a[31:2]} * 32'h9E37_79B1;
    x = x ^ (x >> 15);
    if (x[20]) x[1:0] = 2'b11;
    if (x[21]) x[17:16] = 2'b11;
    return x;
  endfunction

  function automatic logic [15:0] mem_half(input logic [31:0] a);
    logic [31:0] w;
    w = mem_word(a);
    return a[1] ? w[31:16] : w[15:0];
  endfunction

  function automatic logic [31:0] model_inst(input logic [31:0] pc);
    logic [15:0] lo;
    lo = mem_half(pc);
    if (lo[1:0] != 2'b11) return {16'h0, lo};
    return {mem_half(pc + 32'd2), lo};
  endfunction

  // Model state
  logic [31:0] m_pc = '0;
  logic [31:0] last_addr = '0;
  bit          have_word = 0;
  bit          exp_hit_next = 0, exp_bubble_next = 0;
  logic [31:0] exp_reads [$];
  int          n_reads = 0;
  int          lat_force = 0;

  task automatic reset_model();
    exp_reads.delete();
    exp_reads.push_back(32'h0);
    have_word       = 0;
    m_pc            = 32'h0;
    exp_hit_next    = 0;
    exp_bubble_next = 0;
    n_reads         = 0;
  endtask

  // Memory responder: checks each read against the model's expected order
  // and holds the request stable until the response.
  initial begin : responder
    logic [31:0] req_addr;
    int          wait_cnt;
    bit          busy;
    busy = 0;
    wait_cnt = 0;
    req_addr = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        rd_valid = 1'b0;
        busy     = 0;
      end else begin
        if (rd_valid) begin
          rd_valid = 1'b0;
          busy     = 0;
        end
        if (rd_en && !busy) begin
          busy     = 1;
          req_addr = rd_addr;
          wait_cnt = (lat_force > 0) ? lat_force : $urandom_range(1, 3);
          if (exp_reads.size() == 0) begin
            n_chk++;
            $display("FAIL read_order: read at %h, required no read", rd_addr);
          end else begin
            check("read_addr", rd_addr, exp_reads.pop_front());
          end
        end
        if (busy) begin
          check("rd_addr_hold", rd_addr, req_addr);
          check("rd_en_hold", 32'(rd_en), 32'd1);
          check("no_valid_during_read", 32'(inst_valid), 32'd0);
          wait_cnt--;
          if (wait_cnt == 0) begin
            rd_valid  = 1'b1;
            rd_data   = mem_word(req_addr);
            last_addr = req_addr;
            have_word = 1;
            n_reads++;
          end
        end
      end
    end
  end

  // Compare process: outputs vs model on every valid cycle.
  initial begin : compare
    logic [31:0] np;
    logic [15:0] h;
    bit          fits, hit;
    int          idle;
    idle = 0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (exp_hit_next)    check("hit_no_bubble", 32'(inst_valid), 32'd1);
        if (exp_bubble_next) check("miss_bubble", 32'(inst_valid), 32'd0);
        exp_hit_next    = 0;
        exp_bubble_next = 0;
        idle = inst_valid ? 0 : idle + 1;
        if (idle > 200) begin
          $display("FAIL watchdog: inst_valid_o low for %0d cycles, required at most 200", idle);
          $display("%0d/%0d checks passed", n_pass, n_chk + 1);
          $fatal(1, "watchdog expired");
        end
        if (inst_valid) begin
          check("pc_data", pc_data, m_pc);
          check("inst_data", inst_data, model_inst(m_pc));
          if (wr_en) begin
            np   = wr_sel ? (jump_addr & ~32'd1) : m_pc + (inc_sel ? 32'd2 : 32'd4);
            h    = mem_half(np);
            fits = !np[1] || (h[1:0] != 2'b11);
            hit  = have_word && (np[31:2] == last_addr[31:2]) && fits;
            if (hit) begin
              exp_hit_next = 1;
            end else begin
              exp_bubble_next = 1;
              exp_reads.push_back({np[31:2], 2'b00});
              if (!fits) exp_reads.push_back({np[31:2], 2'b00} + 32'd4);
            end
            m_pc = np;
          end
        end
      end
    end
  end

  task automatic wait_valid(output int bubbles);
    bubbles = 0;
    while (!inst_valid && bubbles < 60) begin
      @(posedge clk); #1;
      bubbles++;
    end
    if (!inst_valid) begin
      n_chk++;
      $display("FAIL wait_valid: inst_valid_o 0 after %0d cycles, required 1", bubbles);
    end
  endtask

  task automatic consume(input logic sel, input logic inc, input logic [31:0] j);
    wr_en = 1'b1; wr_sel = sel; inc_sel = inc; jump_addr = j;
    @(posedge clk); #1;
    wr_en = 1'b0; wr_sel = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; wr_en = 1'b0; wr_sel = 1'b0;
    repeat (2) @(posedge clk);
    reset_model();
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin : driver
    int b;
    logic [31:0] r;

    // Reset values
    mem_ovr[32'h0] = 32'h0000_0093;
    reset_model();
    #3;
    check("rst_inst_valid", 32'(inst_valid), 32'd0);
    check("rst_inst_data", inst_data, 32'h0);
    check("rst_pc_data", pc_data, 32'h0);
    check("rst_rd_en", 32'(rd_en), 32'd1);
    check("rst_rd_addr", rd_addr, 32'h0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Sequential 32-bit fetch
    wait_valid(b);
    check("seq_inst", inst_data, 32'h0000_0093);
    check("seq_pc", pc_data, 32'h0);
    consume(1'b0, 1'b0, 32'h0);
    check("seq_next_addr", rd_addr, 32'h4);
    check("seq_next_en", 32'(rd_en), 32'd1);
    wait_valid(b);

    // Compressed pair served from the cache
    mem_ovr[32'h0] = 32'h0001_0001;
    do_reset();
    wait_valid(b);
    check("cpair_inst0", inst_data, 32'h0000_0001);
    consume(1'b0, 1'b1, 32'h0);
    check("cpair_valid1", 32'(inst_valid), 32'd1);
    check("cpair_pc1", pc_data, 32'h2);
    check("cpair_inst1", inst_data, 32'h0000_0001);
    check("cpair_reads", 32'(n_reads), 32'd1);

    // Straddling 32-bit instruction at pc 2
    mem_ovr[32'h0] = 32'h0093_0001;
    mem_ovr[32'h4] = 32'h0000_0000;
    do_reset();
    wait_valid(b);
    check("strad_inst0", inst_data, 32'h0000_0001);
    consume(1'b0, 1'b1, 32'h0);
    wait_valid(b);
    check("strad_inst", inst_data, 32'h0000_0093);
    check("strad_pc", pc_data, 32'h2);
    check("strad_reads", 32'(n_reads), 32'd3);

    // Jump with bit 0 set
    consume(1'b1, 1'b0, 32'h0000_0101);
    check("jump_rd_addr", rd_addr, 32'h100);
    wait_valid(b);
    check("jump_pc", pc_data, 32'h100);

    // Five-cycle memory latency
    lat_force = 5;
    consume(1'b0, 1'b0, 32'h0);
    wait_valid(b);
    check("lat5_bubble", 32'(b), 32'd5);
    check("lat5_pc", pc_data, 32'h104);

    // Reset while the second half of a straddle is being read
    mem_ovr[32'h200] = 32'h0013_0001;
    lat_force = 3;
    consume(1'b1, 1'b0, 32'h0000_0202);
    b = 0;
    while (rd_addr !== 32'h204 && b < 40) begin
      @(posedge clk); #1;
      b++;
    end
    check("fetch_hi_reached", rd_addr, 32'h204);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_inst_valid", 32'(inst_valid), 32'd0);
    check("mid_rst_inst_data", inst_data, 32'h0);
    check("mid_rst_pc_data", pc_data, 32'h0);
    check("mid_rst_rd_en", 32'(rd_en), 32'd1);
    check("mid_rst_rd_addr", rd_addr, 32'h0);
    lat_force = 0;
    repeat (2) @(posedge clk);
    reset_model();
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    wait_valid(b);
    check("refetch_pc", pc_data, 32'h0);
    check("refetch_inst", inst_data, 32'h0000_0001);

    // Randomized traffic, including jumps near the top of the address space
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      wr_en   = ($urandom_range(0, 99) < 60);
      wr_sel  = ($urandom_range(0, 9) == 0);
      inc_sel = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) < 7) r = 32'($urandom_range(0, 511));
      else                          r = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
      jump_addr = r;
    end
    @(posedge clk); #1;
    wr_en = 1'b0;
    repeat (20) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
